// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for a DDS: steps the phase increment through
// n_points values and brackets each point with a settle and a dwell window.
module dds_sweep_ctrl #(
   parameter int unsigned PHI_W  = 32,
   parameter int unsigned CNT_W  = 24,
   parameter int unsigned NPTS_W = 10
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [PHI_W-1:0]  phi_start,
   input  logic [PHI_W-1:0]  phi_step,
   input  logic [NPTS_W-1:0] n_points,
   input  logic [CNT_W-1:0]  settle_cycles,
   input  logic [CNT_W-1:0]  dwell_cycles,
   output logic [PHI_W-1:0]  phi_inc_o,
   output logic              dds_clken,
   output logic              meas_valid,
   output logic              point_start,
   output logic [NPTS_W-1:0] point_idx,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {StIdle, StSettle, StDwell, StNext, StDone} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PHI_W-1:0]    phi_q, phi_d;
   logic [PHI_W-1:0]    step_q, step_d;
   logic [NPTS_W-1:0]   idx_q, idx_d;
   logic [NPTS_W-1:0]   npts_q, npts_d;
   logic [CNT_W-1:0]    settle_q, settle_d;
   logic [CNT_W-1:0]    dwell_q, dwell_d;

   logic [CNT_W-1:0]    settle_len;
   logic [CNT_W-1:0]    dwell_len;
   logic                settle_last;
   logic                dwell_last;
   logic                last_point;

   // Settle never shorter than the DDS output latency; dwell never empty.
   assign settle_len  = (settle_q < CNT_W'(2)) ? CNT_W'(2) : settle_q;
   assign dwell_len   = (dwell_q == '0) ? CNT_W'(1) : dwell_q;
   assign settle_last = (cnt_q == settle_len - CNT_W'(1));
   assign dwell_last  = (cnt_q == dwell_len - CNT_W'(1));
   assign last_point  = (idx_q == npts_q - NPTS_W'(1));

   // State, counter and latched configuration registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         phi_q    <= '0;
         step_q   <= '0;
         idx_q    <= '0;
         npts_q   <= '0;
         settle_q <= '0;
         dwell_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         phi_q    <= phi_d;
         step_q   <= step_d;
         idx_q    <= idx_d;
         npts_q   <= npts_d;
         settle_q <= settle_d;
         dwell_q  <= dwell_d;
      end
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      phi_d    = phi_q;
      step_d   = step_q;
      idx_d    = idx_q;
      npts_d   = npts_q;
      settle_d = settle_q;
      dwell_d  = dwell_q;
      case (state_q)
         StIdle: begin
            // abort has priority over a coincident start
            if (start && !abort) begin
               if (n_points == '0) begin
                  state_d = StDone;
               end else begin
                  state_d  = StSettle;
                  cnt_d    = '0;
                  phi_d    = phi_start;
                  step_d   = phi_step;
                  idx_d    = '0;
                  npts_d   = n_points;
                  settle_d = settle_cycles;
                  dwell_d  = dwell_cycles;
               end
            end
         end
         StSettle: begin
            if (abort) begin
               state_d = StIdle;
            end else if (settle_last) begin
               state_d = StDwell;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StDwell: begin
            if (abort) begin
               state_d = StIdle;
            end else if (dwell_last) begin
               state_d = last_point ? StDone : StNext;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StNext: begin
            if (abort) begin
               state_d = StIdle;
            end else begin
               // increment wraps modulo 2^PHI_W by construction
               state_d = StSettle;
               cnt_d   = '0;
               phi_d   = phi_q + step_q;
               idx_d   = idx_q + NPTS_W'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs decoded from registered state only.
   always_comb begin
      busy        = (state_q == StSettle) || (state_q == StDwell) || (state_q == StNext);
      dds_clken   = busy;
      meas_valid  = (state_q == StDwell);
      point_start = (state_q == StDwell) && (cnt_q == '0);
      done        = (state_q == StDone);
      phi_inc_o   = phi_q;
      point_idx   = idx_q;
   end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: per-cycle expected trace built
// from sweep arithmetic, compared against the DUT outputs.
module tb_dds_sweep_ctrl;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        abort;
   logic [31:0] phi_start;
   logic [31:0] phi_step;
   logic [9:0]  n_points;
   logic [23:0] settle_cycles;
   logic [23:0] dwell_cycles;
   logic [31:0] phi_inc_o;
   logic        dds_clken;
   logic        meas_valid;
   logic        point_start;
   logic [9:0]  point_idx;
   logic        busy;
   logic        done;

   dds_sweep_ctrl #(
      .PHI_W  (32),
      .CNT_W  (24),
      .NPTS_W (10)
   ) u_dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .abort         (abort),
      .phi_start     (phi_start),
      .phi_step      (phi_step),
      .n_points      (n_points),
      .settle_cycles (settle_cycles),
      .dwell_cycles  (dwell_cycles),
      .phi_inc_o     (phi_inc_o),
      .dds_clken     (dds_clken),
      .meas_valid    (meas_valid),
      .point_start   (point_start),
      .point_idx     (point_idx),
      .busy          (busy),
      .done          (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        busy;
      logic        clken;
      logic        meas;
      logic        pstart;
      logic        done;
      logic        chk;    // phi/idx are checked on this cycle
      logic [9:0]  idx;
      logic [31:0] phi;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] obs_ps_phi[$];
   int          obs_done_cyc;
   int          obs_meas_cnt;
   logic [31:0] model_phi;
   logic [9:0]  model_idx;
   int          errors;
   int          checks;

   // Expected cycle-by-cycle trace starting at the cycle after start.
   task automatic build(input logic [31:0] ps, input logic [31:0] st, input int n,
                        input int s, input int d, input int abort_cyc);
      int sl;
      int dl;
      logic [31:0] ph;
      exp_t idle_e;
      exp_q.delete();
      sl = (s < 2) ? 2 : s;
      dl = (d < 1) ? 1 : d;
      if (abort_cyc < 0) begin
         // start+abort together: nothing happens
      end else if (n == 0) begin
         exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, model_idx, model_phi});
      end else begin
         for (int p = 0; p < n; p++) begin
            ph = ps + st * 32'(p);
            for (int c = 0; c < sl; c++)
               exp_q.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'(p), ph});
            for (int c = 0; c < dl; c++)
               exp_q.push_back('{1'b1, 1'b1, 1'b1, c == 0, 1'b0, 1'b1, 10'(p), ph});
            if (p < n - 1)
               exp_q.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'(p), ph});
            else
               exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'(p), ph});
            model_phi = ph;
            model_idx = 10'(p);
         end
         if (abort_cyc > 0) begin
            while (exp_q.size() > abort_cyc) void'(exp_q.pop_back());
            model_phi = exp_q[abort_cyc-1].phi;
            model_idx = exp_q[abort_cyc-1].idx;
         end
      end
      idle_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, model_idx, model_phi};
      exp_q.push_back(idle_e);
      exp_q.push_back(idle_e);
   endtask

   // Start a sweep and compare every cycle against the built trace.
   task automatic run_sweep(input logic [31:0] ps, input logic [31:0] st, input int n,
                            input int s, input int d, input int abort_cyc);
      exp_t e;
      logic [4:0] of;
      logic [4:0] ef;
      build(ps, st, n, s, d, abort_cyc);
      obs_done_cyc = -1;
      obs_meas_cnt = 0;
      obs_ps_phi.delete();
      @(negedge clk);
      phi_start     = ps;
      phi_step      = st;
      n_points      = 10'(n);
      settle_cycles = 24'(s);
      dwell_cycles  = 24'(d);
      start         = 1'b1;
      abort         = (abort_cyc < 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         e  = exp_q[i];
         of = {busy, dds_clken, meas_valid, point_start, done};
         ef = {e.busy, e.clken, e.meas, e.pstart, e.done};
         checks++;
         if (of !== ef) begin
            errors++;
            $display("FAIL flags cyc=%0d busy/clken/meas/pstart/done got=%b exp=%b",
                     i + 1, of, ef);
         end
         if (e.chk) begin
            checks++;
            if (phi_inc_o !== e.phi || point_idx !== e.idx) begin
               errors++;
               $display("FAIL phi_idx cyc=%0d got phi=%h idx=%0d exp phi=%h idx=%0d",
                        i + 1, phi_inc_o, point_idx, e.phi, e.idx);
            end
         end
         if (done === 1'b1 && obs_done_cyc < 0) obs_done_cyc = i + 1;
         if (meas_valid === 1'b1) obs_meas_cnt++;
         if (point_start === 1'b1) obs_ps_phi.push_back(phi_inc_o);
         // configuration changes after the latch must have no effect
         phi_start     = $urandom;
         phi_step      = $urandom;
         n_points      = 10'($urandom);
         settle_cycles = 24'($urandom);
         dwell_cycles  = 24'($urandom);
         start         = (e.busy || e.done) ? 1'($urandom) : 1'b0;
         abort         = (i + 1 == abort_cyc);
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, dds_clken, meas_valid, point_start, done} !== 5'b0 ||
          phi_inc_o !== 32'h0 || point_idx !== 10'h0) begin
         errors++;
         $display("FAIL reset_state got flags=%b phi=%h idx=%0d exp 0",
                  {busy, dds_clken, meas_valid, point_start, done}, phi_inc_o, point_idx);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      model_phi = '0;
      model_idx = '0;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if ({busy, dds_clken, meas_valid, point_start, done} !== 5'b0) begin
            errors++;
            $display("FAIL idle_after_reset got=%b exp=0",
                     {busy, dds_clken, meas_valid, point_start, done});
         end
      end
   endtask

   task automatic test_basic();
      run_sweep(32'h0100_0000, 32'h0010_0000, 3, 4, 5, 0);
      checks++;
      if (obs_done_cyc != 30) begin
         errors++;
         $display("FAIL basic_done_cycle got=%0d exp=30", obs_done_cyc);
      end
      checks++;
      if (obs_meas_cnt != 15) begin
         errors++;
         $display("FAIL basic_meas_count got=%0d exp=15", obs_meas_cnt);
      end
      checks++;
      if (obs_ps_phi.size() != 3) begin
         errors++;
         $display("FAIL basic_points got=%0d exp=3", obs_ps_phi.size());
      end else if (obs_ps_phi[2] !== 32'h0120_0000) begin
         errors++;
         $display("FAIL basic_third_phi got=%h exp=01200000", obs_ps_phi[2]);
      end
   endtask

   task automatic test_wrap();
      run_sweep(32'hFFF0_0000, 32'h0020_0000, 2, 3, 2, 0);
      checks++;
      if (obs_ps_phi.size() != 2) begin
         errors++;
         $display("FAIL wrap_points got=%0d exp=2", obs_ps_phi.size());
      end else if (obs_ps_phi[1] !== 32'h0010_0000) begin
         errors++;
         $display("FAIL wrap_phi got=%h exp=00100000", obs_ps_phi[1]);
      end
   endtask

   task automatic test_minimum();
      run_sweep(32'h1234_5678, 32'h1, 1, 0, 0, 0);
      checks++;
      if (obs_done_cyc != 4) begin
         errors++;
         $display("FAIL min_done_cycle got=%0d exp=4", obs_done_cyc);
      end
   endtask

   task automatic test_abort();
      // settle 1-2, dwell 3-6, next 7, settle 8-9, second dwell 10-13
      run_sweep(32'h0A00_0000, 32'h0000_1000, 3, 2, 4, 11);
      checks++;
      if (obs_done_cyc != -1) begin
         errors++;
         $display("FAIL abort_no_done got done at cyc %0d exp none", obs_done_cyc);
      end
      run_sweep(32'h0B00_0000, 32'h0000_2000, 2, 1, 1, 0);
   endtask

   task automatic test_zero_and_start_abort();
      run_sweep(32'h5555_0000, 32'h10, 0, 3, 3, 0);
      checks++;
      if (obs_done_cyc != 1) begin
         errors++;
         $display("FAIL zero_pts_done got=%0d exp=1", obs_done_cyc);
      end
      run_sweep(32'h6666_0000, 32'h10, 2, 3, 3, -1);
   endtask

   task automatic test_reset_mid_sweep();
      @(negedge clk);
      phi_start     = 32'h7700_0000;
      phi_step      = 32'h100;
      n_points      = 10'd2;
      settle_cycles = 24'd6;
      dwell_cycles  = 24'd2;
      start         = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, dds_clken, meas_valid, point_start, done} !== 5'b0 ||
          phi_inc_o !== 32'h0 || point_idx !== 10'h0) begin
         errors++;
         $display("FAIL async_reset got flags=%b phi=%h idx=%0d exp 0",
                  {busy, dds_clken, meas_valid, point_start, done}, phi_inc_o, point_idx);
      end
      start = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({busy, dds_clken, meas_valid, point_start, done} !== 5'b0) begin
            errors++;
            $display("FAIL start_in_reset got=%b exp=0",
                     {busy, dds_clken, meas_valid, point_start, done});
         end
      end
      start = 1'b0;
      @(posedge clk);
      #3 reset_n = 1'b1;
      model_phi = '0;
      model_idx = '0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({busy, dds_clken, meas_valid, point_start, done} !== 5'b0 ||
             phi_inc_o !== 32'h0) begin
            errors++;
            $display("FAIL idle_after_release got flags=%b phi=%h exp 0",
                     {busy, dds_clken, meas_valid, point_start, done}, phi_inc_o);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] ps;
      logic [31:0] st;
      logic [31:0] save_phi;
      logic [9:0]  save_idx;
      int n, s, d, k, ab;
      for (int t = 0; t < 10; t++) begin
         ps = $urandom;
         st = $urandom;
         n  = $urandom_range(0, 4);
         s  = $urandom_range(0, 5);
         d  = $urandom_range(0, 5);
         ab = 0;
         if (n > 0 && $urandom_range(0, 2) == 0) begin
            save_phi = model_phi;
            save_idx = model_idx;
            build(ps, st, n, s, d, 0);
            k = $urandom_range(1, exp_q.size() - 3);
            if (exp_q[k-1].busy && exp_q[k-1].chk) ab = k;
            model_phi = save_phi;
            model_idx = save_idx;
         end
         run_sweep(ps, st, n, s, d, ab);
      end
   endtask

   initial begin
      errors        = 0;
      checks        = 0;
      start         = 1'b0;
      abort         = 1'b0;
      phi_start     = '0;
      phi_step      = '0;
      n_points      = '0;
      settle_cycles = '0;
      dwell_cycles  = '0;
      model_phi     = '0;
      model_idx     = '0;
      test_reset();
      test_basic();
      test_wrap();
      test_minimum();
      test_abort();
      test_zero_and_start_abort();
      test_reset_mid_sweep();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter PHI_W, default 32, phase-increment width, matching the DDS phi_inc_i.
REQ-002 SHALL have parameter CNT_W, default 24, width of the settle and dwell cycle counters.
REQ-003 SHALL have parameter NPTS_W, default 10, width of the point count and point index.
REQ-004 SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, sweep request, sampled only in IDLE.
REQ-007 SHALL have port abort, input, 1, terminates any sweep in progress.
REQ-008 SHALL have port phi_start, input, PHI_W, increment for the first frequency point.
REQ-009 SHALL have port phi_step, input, PHI_W, increment added between points.
REQ-010 SHALL have port n_points, input, NPTS_W, number of frequency points.
REQ-011 SHALL have port settle_cycles, input, CNT_W, settle length per point.
REQ-012 SHALL have port dwell_cycles, input, CNT_W, measurement window length per point.
REQ-013 SHALL have port phi_inc_o, output, PHI_W, increment driven to the DDS phi_inc_i.
REQ-014 SHALL have port dds_clken, output, 1, driven to the DDS clken.
REQ-015 SHALL have port meas_valid, output, 1, high during the measurement window.
REQ-016 SHALL have port point_start, output, 1, one-cycle pulse on the first dwell cycle of each point.
REQ-017 SHALL have port point_idx, output, NPTS_W, current point index counting from 0.
REQ-018 SHALL have port busy, output, 1, high in SETTLE, DWELL and NEXT.
REQ-019 SHALL have port done, output, 1, one-cycle pulse at normal sweep completion.

Function
REQ-020 SHALL implement FSM states IDLE, SETTLE, DWELL, NEXT and DONE, with all outputs registered or decoded from registered state.
REQ-021 In IDLE, start=1 with abort=0 and n_points>0 SHALL latch all configuration inputs, load phi_inc_o=phi_start and point_idx=0, and enter SETTLE on the next cycle.
REQ-022 In IDLE, start=1 with n_points=0 SHALL go to DONE for one cycle without asserting dds_clken.
REQ-023 SHALL ignore configuration input changes after the latch until the next accepted start.
REQ-024 SETTLE SHALL last exactly max(settle_cycles,2) cycles, with dds_clken=1 and meas_valid=0; the minimum of 2 covers the DDS output latency.
REQ-025 DWELL SHALL last exactly max(dwell_cycles,1) cycles, with dds_clken=1 and meas_valid=1.
REQ-026 point_start SHALL be high only on the first DWELL cycle of each point.
REQ-027 At the end of DWELL, SHALL enter DONE if point_idx==n_points-1, otherwise NEXT.
REQ-028 NEXT SHALL last 1 cycle with dds_clken=1 and meas_valid=0, and SHALL set phi_inc_o+=phi_step (modulo 2^PHI_W, wrap silently) and point_idx+=1 before the next SETTLE.
REQ-029 DONE SHALL last 1 cycle with done=1, busy=0 and dds_clken=0, then return to IDLE.
REQ-030 In IDLE, dds_clken, meas_valid, point_start, busy and done SHALL be 0, and phi_inc_o and point_idx SHALL hold their last values.
REQ-031 start while not in IDLE SHALL be ignored.
REQ-032 abort=1 in SETTLE, DWELL or NEXT SHALL return to IDLE on the next cycle with done never pulsed; abort in DONE SHALL not suppress done.
REQ-033 When start and abort are both 1 in IDLE, abort SHALL win and the sweep SHALL not start.

Reset
REQ-034 reset_n=0 SHALL asynchronously force state=IDLE, phi_inc_o=0, point_idx=0, and dds_clken, meas_valid, point_start, busy and done to 0.
REQ-035 Reset asserted mid-sweep SHALL discard the sweep; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-036 Stimulus: phi_start=0x0100_0000, step=0x0010_0000, n=3, settle=4, dwell=5, start pulsed at cycle 0. Required response: busy on cycles 1-29; meas_valid on cycles 5-9, 15-19 and 25-29; phi_inc_o = 0x0100_0000, 0x0110_0000 and 0x0120_0000 for the three points; done on cycle 30.
REQ-037 Stimulus: phi_start=0xFFF0_0000, step=0x0020_0000, n=2. Required response: the second point's phi_inc_o is 0x0010_0000 (wrap).
REQ-038 Stimulus: settle=0, dwell=0, n=1. Required response: SETTLE lasts 2 cycles, DWELL lasts 1 cycle, point_start and meas_valid are coincident, and done follows.
REQ-039 Stimulus: abort during the second DWELL. Required response: IDLE on the next cycle, no done, dds_clken=0; a new start is then accepted.
REQ-040 Stimulus: start with n_points=0, and separately start+abort in the same cycle. Required response: the first gives done only with no clken; the second gives no activity.
REQ-041 Stimulus: reset_n pulsed low mid-SETTLE. Required response: all outputs 0 immediately (asynchronously), and start is ignored until reset_n is released.
